uart_receiver: RTL and testbench

- Serial-to-parallel UART receive stage; sits directly upstream of the peripheral register block.
- Takes the raw UART_RX pin and a 16x-oversampling baud tick.
- Delivers one received byte on rx_data with a one-cycle RX_END strobe, plus busy and framing-error status.
- Format fixed at 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.

---
 rtl/uart_receiver.sv | 122 ++++++++++++
 tb/tb_uart_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: 2-flop input synchronizer, 16x-oversampled bit recovery,
// one-cycle RX_END / rx_ferr strobes and a frame-in-progress status flag.
module uart_receiver #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_Baud,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 RX_END,
  output logic                 rx_status,
  output logic                 rx_ferr
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TcntHalf = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TcntTop  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BcntLast = BW'(DATA_BITS - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  logic                 sync1_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_end_q, rx_end_d;
  logic                 rx_ferr_q, rx_ferr_d;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_end_d  = 1'b0;
    rx_ferr_d = 1'b0;
    if (clk_Baud) begin
      tcnt_d = (tcnt_q == TcntTop) ? '0 : tcnt_q + TW'(1);
      case (state_q)
        StIdle: begin
          tcnt_d = '0;
          if (!rx_s_q) begin
            state_d = StStart;
            tcnt_d  = TW'(1);
          end
        end
        StStart: begin
          if (tcnt_q == TcntHalf) begin
            // Line back high at mid start bit: treat as a glitch
            state_d = rx_s_q ? StIdle : StData;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end
        end
        StData: begin
          if (tcnt_q == TcntTop) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == BcntLast) begin
              state_d = StStop;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
            end
          end
        end
        StStop: begin
          // Leaving at mid stop bit gives half a bit of slack for back-to-back frames
          if (tcnt_q == TcntTop) begin
            state_d = StIdle;
            tcnt_d  = '0;
            if (rx_s_q) begin
              rx_data_d = shift_q;
              rx_end_d  = 1'b1;
            end else begin
              rx_ferr_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      rx_end_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
    end else begin
      sync1_q   <= UART_RX;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rx_end_q  <= rx_end_d;
      rx_ferr_q <= rx_ferr_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign RX_END    = rx_end_q;
  assign rx_ferr   = rx_ferr_q;
  assign rx_status = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are pushed as expectations when driven
// and checked when RX_END / rx_ferr fire.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_Baud = 1'b1;
  logic       UART_RX = 1'b1;
  logic [7:0] rx_data;
  logic       RX_END, rx_status, rx_ferr;

  uart_receiver #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_Baud  (clk_Baud),
    .UART_RX   (UART_RX),
    .rx_data   (rx_data),
    .RX_END    (RX_END),
    .rx_status (rx_status),
    .rx_ferr   (rx_ferr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         div = 1;
  int         div_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One baud tick every div clocks
  always @(negedge clk) begin
    if (div_cnt >= div - 1) div_cnt = 0;
    else div_cnt = div_cnt + 1;
    clk_Baud = (div_cnt == 0);
  end

  always @(negedge clk) begin
    if (RX_END || rx_ferr) begin
      check("status_low_on_strobe", rx_status, 1'b0);
      if (exp_q.size() == 0) begin
        check("spurious_event", {RX_END, rx_ferr}, 2'b00);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {RX_END, rx_ferr}, e.err ? 2'b01 : 2'b10);
        if (!e.err) last_good = e.data;
        check("rx_data", rx_data, last_good);
      end
    end
  end

  task automatic drive_bit(input logic b, input int ticks);
    UART_RX = b;
    repeat (ticks * div) @(negedge clk);
  endtask

  // Short stop on a bad frame lets the receiver see the line high before its next mid-start check
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.err  = !stop_ok;
    e.data = b;
    exp_q.push_back(e);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    if (stop_ok) drive_bit(1'b1, 16);
    else begin
      drive_bit(1'b0, 12);
      drive_bit(1'b1, 4);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int activity;
    int lat;
    logic seen;

    // Reset and idle
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_strobes", {RX_END, rx_ferr, rx_status}, 3'b000);
    reset = 1'b1;
    activity = 0;
    repeat (100) begin
      @(negedge clk);
      if (RX_END || rx_status || rx_ferr || rx_data != 8'h00) activity++;
    end
    check("idle_activity", activity, 0);

    // Single 0x55 with latency: sync (2) + edge detect + 9.5 bit periods to mid stop
    lat = 0;
    fork
      send_frame(8'h55, 1'b1);
      begin
        while (!RX_END && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("latency_0x55", lat, 154);
    wait_drain("drain_0x55");
    check("hold_0x55", rx_data, 8'h55);

    // Back-to-back frames, tick every 4 clocks
    div = 4;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    drive_bit(1'b1, 16);
    wait_drain("drain_b2b");
    check("hold_0x0f", rx_data, 8'h0F);

    // Glitch rejection
    div = 1;
    repeat (40) @(negedge clk);
    UART_RX = 1'b0;
    repeat (5) @(negedge clk);
    UART_RX = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rx_status) seen = 1'b1;
    end
    check("glitch_status_seen", seen, 1'b1);
    check("glitch_status_idle", rx_status, 1'b0);
    check("glitch_rx_data", rx_data, 8'h0F);

    // Framing error then a good frame
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, 32);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 16);
    wait_drain("drain_ferr");
    check("hold_0x81", rx_data, 8'h81);

    // Reset mid data bit 4 of 0xFF
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    reset = 1'b0;
    #1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_outputs", {RX_END, rx_ferr, rx_status}, 3'b000);
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    drive_bit(1'b1, 16);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, 16);
    wait_drain("drain_0x12");
    check("hold_0x12", rx_data, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
